wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Register-file write-port arbiter for the MIPS writeback stage. Shares the single register-file write port between the in-order pipeline's MEM/WB result and results returned by the multi-cycle multiply/divide unit (MDU). Pipeline writes take priority. MDU results queue in a small FIFO and drain into idle write-port cycles. A registered stall forces a drain when the FIFO fills. The block also performs the JAL link-data selection (PC+8 vs. normal write data).

## Interface
- BITS_SIZE, 32, data width
- REG_ADDR, 5, register address width
- PEND_DEPTH, 2, MDU pending-FIFO entries (≥1)

- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_wb_valid  in  1  MEM/WB stage holds a valid instruction
- i_wb_regwrite  in  1  instruction writes the register file
- i_wb_jal  in  1  select i_wb_pc8 as write data
- i_wb_reg_addr  in  REG_ADDR  destination register
- i_wb_data  in  BITS_SIZE  ALU/memory result
- i_wb_pc8  in  BITS_SIZE  PC+8 link value
- i_mdu_valid  in  1  MDU result offered
- i_mdu_reg_addr  in  REG_ADDR  MDU destination
- i_mdu_data  in  BITS_SIZE  MDU result
- o_mdu_ready  out  1  FIFO can accept; transfer = i_mdu_valid & o_mdu_ready
- o_rf_write  out  1  register-file write enable (registered)
- o_rf_addr  out  REG_ADDR  write address (registered)
- o_rf_data  out  BITS_SIZE  write data (registered)
- o_stall_pipe  out  1  freeze pipeline up to and including MEM/WB (registered, = state==DRAIN)

## Operation
- Pipeline write is effective (pw) when i_wb_valid & i_wb_regwrite & (i_wb_reg_addr != 0).
- Pipeline data = i_wb_jal ? i_wb_pc8 : i_wb_data. Address is always i_wb_reg_addr; upstream RegDst selects 31 for JAL.
- FIFO: PEND_DEPTH entries of {addr, data}, plus a count register covering 0..PEND_DEPTH. Pointers wrap modulo PEND_DEPTH.
- o_mdu_ready = !i_reset & (count < PEND_DEPTH).
- An accepted MDU result with addr 0 is consumed and discarded: it is not pushed and count is unchanged.
- States:
  - NORMAL:
    - If pw, write the pipeline result; the FIFO is not popped.
    - Otherwise, if count > 0, pop the head and write it.
    - Otherwise o_rf_write = 0 next cycle.
  - DRAIN:
    - Pipeline inputs are ignored (the pipeline is stalled and holds them stable).
    - Pop the head and write it each cycle.
- Transitions, evaluated on next-count (after this cycle's push and pop):
  - NORMAL→DRAIN when next-count == PEND_DEPTH.
  - DRAIN→NORMAL when next-count == 0.
  - In DRAIN, pushes are still accepted while o_mdu_ready = 1.
- Simultaneous push and pop in one cycle is allowed; count is unchanged.
- No bypass: an MDU result pushed in cycle N appears on o_rf_* no earlier than after edge N+1.
- No ordering/hazard checks between pipeline and MDU writes to the same register. The hazard unit is responsible for ordering.

## Timing
- Reset, applied at an edge while i_reset = 1:
  - o_rf_write = 0, o_rf_addr = 0, o_rf_data = 0.
  - o_stall_pipe = 0, state = NORMAL, count = 0, pointers = 0.
  - FIFO contents discarded, including mid-DRAIN.
  - o_mdu_ready = 0 while i_reset is high.
- Latency: inputs sampled at edge N produce o_rf_* valid after edge N (one cycle). The register file writes them on edge N+1.
- o_stall_pipe rises the cycle after the edge at which the FIFO became full. It falls the cycle after the edge at which the last entry popped.
- The FIFO can become full in the same cycle a pw occurs. The pipeline write wins, and DRAIN begins next cycle.
- Full FIFO with i_mdu_valid high: the offer is not accepted. The MDU must hold valid/addr/data stable until accepted.

## Test plan
- **Reset:** i_reset = 1 for 2 cycles with all inputs toggling → all outputs 0, o_mdu_ready = 0; first edge after release gives o_mdu_ready = 1.
- **JAL select:** pw with jal = 1, addr = 31, pc8 = 0x0040_0010, data = 0xDEAD_BEEF → next cycle o_rf_write = 1, addr = 31, data = 0x0040_0010. Same with jal = 0 → data 0xDEAD_BEEF. Addr = 0 → o_rf_write = 0.
- **Idle-slot drain:** MDU pushes {addr 8, 0x1234} while pw is continuous for 3 cycles → no MDU write. At the first cycle without pw, o_rf_write = 1, addr = 8, data = 0x1234 one cycle later.
- **Forced drain:** with PEND_DEPTH = 2 and pw every cycle, push {9, 0xA} then {10, 0xB}:
  - o_stall_pipe = 1 the next cycle.
  - The two following cycles write 9/0xA, then 10/0xB, ignoring pipeline inputs.
  - o_stall_pipe = 0 after count reaches 0.
  - A third MDU offer while full sees o_mdu_ready = 0 and is accepted only after the first pop.
- **Simultaneous push/pop:** count = 1 in NORMAL with no pw, plus a new push → head written, count stays 1, no DRAIN entry.
- **Reset mid-DRAIN:** assert i_reset with count = 2 → next cycle o_stall_pipe = 0, o_rf_write = 0, and no stale entries are written afterwards.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, MDU results
// queue in a small FIFO and drain into idle slots or a forced stall.
module wb_write_arbiter #(
  parameter int BITS_SIZE  = 32,
  parameter int REG_ADDR   = 5,
  parameter int PEND_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_regwrite,
  input  logic                 i_wb_jal,
  input  logic [REG_ADDR-1:0]  i_wb_reg_addr,
  input  logic [BITS_SIZE-1:0] i_wb_data,
  input  logic [BITS_SIZE-1:0] i_wb_pc8,
  input  logic                 i_mdu_valid,
  input  logic [REG_ADDR-1:0]  i_mdu_reg_addr,
  input  logic [BITS_SIZE-1:0] i_mdu_data,
  output logic                 o_mdu_ready,
  output logic                 o_rf_write,
  output logic [REG_ADDR-1:0]  o_rf_addr,
  output logic [BITS_SIZE-1:0] o_rf_data,
  output logic                 o_stall_pipe
);

  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(PEND_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PEND_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PEND_DEPTH - 1);

  typedef enum logic {
    NORMAL,
    DRAIN
  } state_t;

  state_t state;
  state_t next_state;

  logic [REG_ADDR-1:0]  pend_addr [PEND_DEPTH];
  logic [BITS_SIZE-1:0] pend_data [PEND_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;

  logic                 pw;
  logic [BITS_SIZE-1:0] pipe_data;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [REG_ADDR-1:0]  head_addr;
  logic [BITS_SIZE-1:0] head_data;

  assign o_mdu_ready = !i_reset && (count < FULL_CNT);

  assign head_addr = pend_addr[rd_ptr];
  assign head_data = pend_data[rd_ptr];

  always_comb begin
    pw        = i_wb_valid && i_wb_regwrite &&
                (i_wb_reg_addr != '0);
    pipe_data = i_wb_jal ? i_wb_pc8 : i_wb_data;
    accept    = i_mdu_valid && o_mdu_ready;
    // Results for $zero are consumed but never stored.
    push      = accept && (i_mdu_reg_addr != '0);
    pop       = 1'b0;
    if (count != '0) begin
      if (state == DRAIN) pop = 1'b1;
      else                pop = !pw;
    end
    next_count = count + CNT_W'(push) - CNT_W'(pop);
    next_state = state;
    if (state == NORMAL) begin
      if (next_count == FULL_CNT) next_state = DRAIN;
    end else begin
      if (next_count == '0) next_state = NORMAL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pend_addr[wr_ptr] <= i_mdu_reg_addr;
      pend_data[wr_ptr] <= i_mdu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= NORMAL;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_rf_write   <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_data    <= '0;
      o_stall_pipe <= 1'b0;
    end else begin
      state        <= next_state;
      count        <= next_count;
      o_stall_pipe <= (next_state == DRAIN);
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (state == NORMAL && pw) begin
        o_rf_write <= 1'b1;
        o_rf_addr  <= i_wb_reg_addr;
        o_rf_data  <= pipe_data;
      end else if (pop) begin
        o_rf_write <= 1'b1;
        o_rf_addr  <= head_addr;
        o_rf_data  <= head_data;
      end else begin
        o_rf_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter (PEND_DEPTH = 2).
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_regwrite;
  logic        wb_jal;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc8;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(
    .BITS_SIZE (32),
    .REG_ADDR  (5),
    .PEND_DEPTH(2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_valid    (wb_valid),
    .i_wb_regwrite (wb_regwrite),
    .i_wb_jal      (wb_jal),
    .i_wb_reg_addr (wb_addr),
    .i_wb_data     (wb_data),
    .i_wb_pc8      (wb_pc8),
    .i_mdu_valid   (mdu_valid),
    .i_mdu_reg_addr(mdu_addr),
    .i_mdu_data    (mdu_data),
    .o_mdu_ready   (mdu_ready),
    .o_rf_write    (rf_write),
    .o_rf_addr     (rf_addr),
    .o_rf_data     (rf_data),
    .o_stall_pipe  (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pw(input logic v, input logic [4:0] a,
                        input logic [31:0] d);
    wb_valid    = v;
    wb_regwrite = v;
    wb_jal      = 1'b0;
    wb_addr     = a;
    wb_data     = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a,
                         input logic [31:0] d);
    mdu_valid = v;
    mdu_addr  = a;
    mdu_data  = d;
  endtask

  task automatic chk_rf(input string tag, input logic w,
                        input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_write}, {31'd0, w});
    if (w) begin
      chk({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
      chk({tag, "_data"}, rf_data, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_pw(1'b1, 5'd5, 32'h1111_1111);
    wb_pc8 = 32'h2222_2222;
    set_mdu(1'b1, 5'd3, 32'h3333_3333);

    // reset with toggling inputs
    tick();
    set_pw(1'b1, 5'd6, 32'h4444_4444);
    wb_jal = 1'b1;
    set_mdu(1'b1, 5'd7, 32'h5555_5555);
    tick();
    chk("rst_we", {31'd0, rf_write}, 32'd0);
    chk("rst_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ready", {31'd0, mdu_ready}, 32'd0);
    rst = 1'b0;
    set_pw(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("rel_ready", {31'd0, mdu_ready}, 32'd1);
    chk_rf("rel", 1'b0, 5'd0, 32'd0);

    // JAL link-data select
    set_pw(1'b1, 5'd31, 32'hDEAD_BEEF);
    wb_jal = 1'b1;
    wb_pc8 = 32'h0040_0010;
    tick();
    chk_rf("jal1", 1'b1, 5'd31, 32'h0040_0010);
    wb_jal = 1'b0;
    tick();
    chk_rf("jal0", 1'b1, 5'd31, 32'hDEAD_BEEF);
    wb_addr = 5'd0;
    tick();
    chk_rf("zero_addr", 1'b0, 5'd0, 32'd0);

    // idle-slot drain
    set_pw(1'b1, 5'd4, 32'h0000_0044);
    set_mdu(1'b1, 5'd8, 32'h0000_1234);
    chk("idle_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk_rf("idle_pw1", 1'b1, 5'd4, 32'h44);
    tick();
    chk_rf("idle_pw2", 1'b1, 5'd4, 32'h44);
    tick();
    chk_rf("idle_pw3", 1'b1, 5'd4, 32'h44);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    set_pw(1'b0, 5'd0, 32'd0);
    tick();
    chk_rf("idle_pop", 1'b1, 5'd8, 32'h1234);
    tick();
    chk_rf("idle_empty", 1'b0, 5'd0, 32'd0);

    // forced drain with third offer while full
    set_pw(1'b1, 5'd4, 32'h0000_0055);
    set_mdu(1'b1, 5'd9, 32'h0000_000A);
    tick();
    chk_rf("fd_a", 1'b1, 5'd4, 32'h55);
    chk("fd_a_stall", {31'd0, stall}, 32'd0);
    set_mdu(1'b1, 5'd10, 32'h0000_000B);
    tick();
    chk_rf("fd_b", 1'b1, 5'd4, 32'h55);
    chk("fd_b_stall", {31'd0, stall}, 32'd1);
    chk("fd_full_ready", {31'd0, mdu_ready}, 32'd0);
    set_mdu(1'b1, 5'd11, 32'h0000_000C);
    tick();
    chk_rf("fd_pop9", 1'b1, 5'd9, 32'hA);
    chk("fd_c_stall", {31'd0, stall}, 32'd1);
    chk("fd_c_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk_rf("fd_pop10", 1'b1, 5'd10, 32'hB);
    chk("fd_d_stall", {31'd0, stall}, 32'd1);
    tick();
    chk_rf("fd_pop11", 1'b1, 5'd11, 32'hC);
    chk("fd_e_stall", {31'd0, stall}, 32'd0);
    tick();
    chk_rf("fd_resume", 1'b1, 5'd4, 32'h55);

    // simultaneous push and pop
    set_mdu(1'b1, 5'd12, 32'h0000_0012);
    tick();
    chk_rf("pp_fill", 1'b1, 5'd4, 32'h55);
    set_pw(1'b0, 5'd0, 32'd0);
    set_mdu(1'b1, 5'd13, 32'h0000_0013);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk_rf("pp_head", 1'b1, 5'd12, 32'h12);
    chk("pp_stall", {31'd0, stall}, 32'd0);
    tick();
    chk_rf("pp_second", 1'b1, 5'd13, 32'h13);
    chk("pp_stall2", {31'd0, stall}, 32'd0);
    tick();
    chk_rf("pp_empty", 1'b0, 5'd0, 32'd0);

    // MDU result to $zero is discarded
    set_mdu(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk_rf("z_disc1", 1'b0, 5'd0, 32'd0);
    tick();
    chk_rf("z_disc2", 1'b0, 5'd0, 32'd0);

    // reset mid-DRAIN
    set_pw(1'b1, 5'd4, 32'h0000_0066);
    set_mdu(1'b1, 5'd14, 32'h0000_0014);
    tick();
    set_mdu(1'b1, 5'd15, 32'h0000_0015);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk("rd_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rd_stall0", {31'd0, stall}, 32'd0);
    chk("rd_we0", {31'd0, rf_write}, 32'd0);
    chk("rd_ready0", {31'd0, mdu_ready}, 32'd0);
    rst = 1'b0;
    set_pw(1'b0, 5'd0, 32'd0);
    tick();
    chk_rf("rd_nostale1", 1'b0, 5'd0, 32'd0);
    tick();
    chk_rf("rd_nostale2", 1'b0, 5'd0, 32'd0);
    chk("rd_ready1", {31'd0, mdu_ready}, 32'd1);
    chk("rd_stall1", {31'd0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
